// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with a double-buffered frame,
// leading-zero suppression, per-digit blanking and configurable line polarity.
module seg_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg_scan_driver: DIGITS must be in 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("seg_scan_driver: SCAN_DIV must be at least 2");
    end

    typedef struct packed {
        logic [4*DIGITS-1:0] val;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
        logic                lz;
    } frame_t;

    localparam frame_t FRAME_RST = frame_t'{val: '0, dp: '0, blank: '1, lz: 1'b0};

    // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3f;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5b;
            4'h3: g = 7'h4f;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6d;
            4'h6: g = 7'h7d;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7f;
            4'h9: g = 7'h6f;
            4'ha: g = 7'h77;
            4'hb: g = 7'h7c;
            4'hc: g = 7'h39;
            4'hd: g = 7'h5e;
            4'he: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    frame_t            shadow;
    frame_t            disp;
    frame_t            in_frame;
    logic              tc;
    logic              last;
    logic              wrap;
    logic [DIGITS-1:0] dark;
    logic              all_zero;
    logic [3:0]        cur_nib;
    logic [7:0]        seg_next;
    logic [DIGITS-1:0] sel_next;

    assign in_frame = frame_t'{val: value, dp: dp_mask, blank: blank_mask, lz: lz_en};
    assign tc       = (cnt == CW'(SCAN_DIV - 1));
    assign last     = (idx == IW'(DIGITS - 1));
    assign wrap     = tc && last;

    // Scan from the top digit down so each digit knows whether it and all above are blank zeros.
    always_comb begin
        dark     = '0;
        all_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero = all_zero && (disp.val[4*i +: 4] == 4'h0) && !disp.dp[i];
            dark[i]  = disp.blank[i] || (disp.lz && (i >= 1) && all_zero);
        end
    end

    always_comb begin
        cur_nib  = disp.val[4*int'(idx) +: 4];
        seg_next = dark[idx] ? 8'h00 : {disp.dp[idx], glyph(cur_nib)};
        sel_next = dark[idx] ? '0 : (DIGITS'(1) << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            shadow     <= FRAME_RST;
            disp       <= FRAME_RST;
            seg_out    <= {8{SEG_ACTIVE_LOW}};
            dig_sel    <= {DIGITS{DIG_ACTIVE_LOW}};
            frame_done <= 1'b0;
        end else begin
            cnt <= tc ? '0 : cnt + CW'(1);
            if (tc) begin
                idx <= last ? '0 : idx + IW'(1);
            end
            if (load) begin
                shadow <= in_frame;
            end
            // A load on the wrap cycle bypasses the shadow so it is not a frame late.
            if (wrap) begin
                disp <= load ? in_frame : shadow;
            end
            frame_done <= wrap;
            seg_out    <= seg_next ^ {8{SEG_ACTIVE_LOW}};
            dig_sel    <= sel_next ^ {DIGITS{DIG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, SCAN_DIV=4, active-low lines) against a
// frame-level reference model driven by directed and random stimulus.
module tb_seg_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int FR = D * SD;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        lz;
    } fr_t;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic        load;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    seg_scan_driver #(
        .DIGITS(D), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .lz_en(lz_en), .load(load),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          t        = 0;
    fr_t         m_sh;
    fr_t         m_disp;
    fr_t         fr_rst;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_fd;

    function automatic bit m_dark(input fr_t f, input int i);
        return f.bl[i] || (f.lz && i >= 1 && (f.v >> (4*i)) == 16'h0 && (f.dp >> i) == 4'h0);
    endfunction

    function automatic logic [7:0] m_seg(input fr_t f, input int i);
        logic [3:0] n;
        n = 4'((f.v >> (4*i)) & 16'hf);
        return m_dark(f, i) ? 8'hff : ~{f.dp[i], GLYPH[n]};
    endfunction

    function automatic logic [3:0] m_dig(input fr_t f, input int i);
        return m_dark(f, i) ? 4'hf : ~(4'b0001 << i);
    endfunction

    function automatic logic [15:0] rand_val();
        logic [15:0] r;
        r = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(1) == 0) r[4*k +: 4] = 4'h0;
        end
        return r;
    endfunction

    // Check the current cycle, drive the next one, and advance the model by one clock.
    task automatic do_cycle(input bit r, input bit ld, input logic [15:0] v,
                            input logic [3:0] dp, input logic [3:0] bl, input bit lz);
        fr_t nf;
        int  ix;
        bit  wr;
        n_assert++;
        assert (seg_out === exp_seg) else begin
            n_fail++;
            $error("FAIL seg_out t=%0d observed %h expected %h", t, seg_out, exp_seg);
        end
        n_assert++;
        assert (dig_sel === exp_dig) else begin
            n_fail++;
            $error("FAIL dig_sel t=%0d observed %b expected %b", t, dig_sel, exp_dig);
        end
        n_assert++;
        assert (frame_done === exp_fd) else begin
            n_fail++;
            $error("FAIL frame_done t=%0d observed %b expected %b", t, frame_done, exp_fd);
        end
        rst = r; load = ld; value = v; dp_mask = dp; blank_mask = bl; lz_en = lz;
        nf = '{v, dp, bl, lz};
        if (r) begin
            exp_seg = 8'hff; exp_dig = 4'hf; exp_fd = 1'b0;
            m_sh = fr_rst; m_disp = fr_rst; t = 0;
        end else begin
            ix = (t / SD) % D;
            wr = (t % FR) == FR - 1;
            exp_seg = m_seg(m_disp, ix);
            exp_dig = m_dig(m_disp, ix);
            exp_fd  = wr;
            if (wr) m_disp = ld ? nf : m_sh;
            if (ld) m_sh = nf;
            t++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            do_cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < FR && (t % FR) != ph; k++) idle(1);
    endtask

    initial begin
        fr_rst = '{16'h0, 4'h0, 4'hf, 1'b0};
        rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_mask = '0; lz_en = 1'b0;
        m_sh = fr_rst; m_disp = fr_rst;
        exp_seg = 8'hff; exp_dig = 4'hf; exp_fd = 1'b0;
        @(negedge clk);

        // Loads during reset are ignored.
        do_cycle(1'b1, 1'b1, 16'h5678, 4'h0, 4'h0, 1'b0);
        do_cycle(1'b1, 1'b1, 16'h9abc, 4'h0, 4'h0, 1'b0);

        // Idle after release: dark display, frame_done every 16 cycles.
        idle(40);

        // 1234 without suppression.
        wait_phase(3);
        do_cycle(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        idle(36);

        // 0070 with lz and dp on digit 0.
        do_cycle(1'b0, 1'b1, 16'h0070, 4'b0001, 4'h0, 1'b1);
        idle(36);

        // 1234 displayed, then AAAA loaded mid-frame.
        do_cycle(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        wait_phase(6);
        do_cycle(1'b0, 1'b1, 16'haaaa, 4'h0, 4'h0, 1'b0);
        idle(36);

        // FFFF loaded exactly on the wrap cycle.
        wait_phase(FR - 1);
        do_cycle(1'b0, 1'b1, 16'hffff, 4'h0, 4'h0, 1'b0);
        idle(20);

        // Pending shadow load then a one-cycle reset mid-frame.
        wait_phase(5);
        do_cycle(1'b0, 1'b1, 16'h4321, 4'h0, 4'h0, 1'b0);
        idle(2);
        do_cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        idle(40);

        // Random traffic with multiple loads per frame and occasional resets.
        for (int k = 0; k < 800; k++) begin
            do_cycle(($urandom_range(199) == 0),
                     ($urandom_range(5) == 0),
                     rand_val(),
                     ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0,
                     ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0,
                     1'($urandom));
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
